// File: rtl/neurosync_pkg.sv
// ---------------------------------------------------------------------------
// neurosync_pkg
// Shared definitions for the neurosync LED sequencer:
//   - estado_t     : FSM states; the encoding doubles as the 4-bit debug code
//   - NIVEL_*      : difficulty level encoding
//   - *_DEF        : default timing / blink-count constants
//   - largura_contador : width of the shared on/off timer counters
// ---------------------------------------------------------------------------
package neurosync_pkg;

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        ACESO   = 4'd1,
        APAGADO = 4'd2,
        FIM     = 4'd3
    } estado_t;

    localparam logic NIVEL_FACIL   = 1'b0;
    localparam logic NIVEL_DIFICIL = 1'b1;

    localparam int ON_CYCLES_DEF        = 25000000;
    localparam int OFF_CYCLES_DEF       = 12500000;
    localparam int PISCADAS_FACIL_DEF   = 2;
    localparam int PISCADAS_DIFICIL_DEF = 4;

    // Width able to hold 0..max(a,b)-1; never narrower than one bit so a
    // one-cycle phase still yields a legal vector.
    function automatic int largura_contador(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/contador_m.sv
// ---------------------------------------------------------------------------
// contador_m
// Generic modulo-M counter.
//   clock   in  : rising-edge clock
//   reset_n in  : asynchronous active-low reset (count -> 0)
//   zera    in  : synchronous clear, wins over conta
//   conta   in  : advance by one; wraps to 0 after M-1
//   fim     out : high while the count equals M-1 (last cycle of the period)
// ---------------------------------------------------------------------------
module contador_m #(
    parameter int M = 4,
    parameter int W = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [W-1:0] q;

    assign fim = (q == W'(M - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            q <= fim ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/neurosync_led_sequencer.sv
// ---------------------------------------------------------------------------
// neurosync_led_sequencer
// Blinks a latched 4-bit LED pattern a level-dependent number of times and
// pulses fimPiscaLeds when the presentation completes.
//   clock         in  : rising-edge clock
//   reset_n       in  : asynchronous active-low reset
//   iniciar       in  : start request, honoured only in OCIOSO
//   abortar       in  : abort, returns to OCIOSO; priority over iniciar
//   nivel         in  : 0 = facil, 1 = dificil (sampled with iniciar)
//   padrao        in  : LED pattern (sampled with iniciar)
//   leds          out : LED drive
//   ocupado       out : presentation in progress
//   fimPiscaLeds  out : one-cycle pulse at the end of a full presentation
//   piscada_atual out : completed blinks of the current presentation
//   db_estado     out : FSM state code for the debug display
//
// Handshake: iniciar is a level request; it is accepted on any rising edge
// where the FSM is in OCIOSO and abortar is low. There is no acknowledge other
// than ocupado rising in the following cycle.
//
// All outputs come straight from flops. leds/ocupado/fimPiscaLeds are
// computed from the next state so they change on the same edge as the state.
// ---------------------------------------------------------------------------
module neurosync_led_sequencer
    import neurosync_pkg::*;
#(
    parameter int ON_CYCLES        = ON_CYCLES_DEF,
    parameter int OFF_CYCLES       = OFF_CYCLES_DEF,
    parameter int PISCADAS_FACIL   = PISCADAS_FACIL_DEF,
    parameter int PISCADAS_DIFICIL = PISCADAS_DIFICIL_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       abortar,
    input  logic       nivel,
    input  logic [3:0] padrao,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       fimPiscaLeds,
    output logic [3:0] piscada_atual,
    output logic [3:0] db_estado
);

    localparam int CW = largura_contador(ON_CYCLES, OFF_CYCLES);

    estado_t    state_q, state_d;
    logic [3:0] padrao_q, padrao_d;
    logic       nivel_q, nivel_d;
    logic [3:0] piscada_q, piscada_d;
    logic [3:0] leds_q, leds_d;
    logic       ocupado_q, ocupado_d;
    logic       fim_q, fim_d;
    logic [3:0] n_alvo;

    logic zera_on, conta_on, fim_on;
    logic zera_off, conta_off, fim_off;

    // Target blink count follows the level latched at start, not the live input.
    assign n_alvo = (nivel_q == NIVEL_DIFICIL) ? 4'(PISCADAS_DIFICIL) : 4'(PISCADAS_FACIL);

    contador_m #(.M(ON_CYCLES), .W(CW)) u_cont_aceso (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (zera_on),
        .conta   (conta_on),
        .fim     (fim_on)
    );

    contador_m #(.M(OFF_CYCLES), .W(CW)) u_cont_apagado (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (zera_off),
        .conta   (conta_off),
        .fim     (fim_off)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= OCIOSO;
            padrao_q  <= '0;
            nivel_q   <= 1'b0;
            piscada_q <= '0;
            leds_q    <= '0;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            padrao_q  <= padrao_d;
            nivel_q   <= nivel_d;
            piscada_q <= piscada_d;
            leds_q    <= leds_d;
            ocupado_q <= ocupado_d;
            fim_q     <= fim_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        padrao_d  = padrao_q;
        nivel_d   = nivel_q;
        piscada_d = piscada_q;
        zera_on   = 1'b0;
        conta_on  = 1'b0;
        zera_off  = 1'b0;
        conta_off = 1'b0;

        if (abortar) begin
            state_d   = OCIOSO;
            piscada_d = '0;
            zera_on   = 1'b1;
            zera_off  = 1'b1;
        end else begin
            case (state_q)
                OCIOSO: begin
                    zera_on  = 1'b1;
                    zera_off = 1'b1;
                    if (iniciar) begin
                        padrao_d  = padrao;
                        nivel_d   = nivel;
                        piscada_d = '0;
                        state_d   = ACESO;
                    end
                end
                ACESO: begin
                    conta_on = 1'b1;
                    if (fim_on) begin
                        piscada_d = piscada_q + 4'd1;
                        state_d   = APAGADO;
                    end
                end
                APAGADO: begin
                    conta_off = 1'b1;
                    if (fim_off) begin
                        state_d = (piscada_q == n_alvo) ? FIM : ACESO;
                    end
                end
                FIM: begin
                    // iniciar is not looked at here, which guarantees at least
                    // one OCIOSO cycle between back-to-back presentations.
                    state_d = OCIOSO;
                end
                default: begin
                    state_d = OCIOSO;
                end
            endcase
        end

        leds_d    = (state_d == ACESO) ? padrao_d : 4'd0;
        ocupado_d = (state_d != OCIOSO);
        fim_d     = (state_d == FIM);
    end

    assign leds          = leds_q;
    assign ocupado       = ocupado_q;
    assign fimPiscaLeds  = fim_q;
    assign piscada_atual = piscada_q;
    assign db_estado     = state_q;

endmodule

// File: tb/tb_neurosync_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neurosync_led_sequencer
// Cycle-level bench for neurosync_led_sequencer with short timing parameters.
// Cycle c is the clock period that follows rising edge c-1; inputs driven for
// "edge c" are sampled on rising edge c. Expected output vectors are derived
// from the presentation timing (blink index / phase arithmetic) and queued
// when stimulus is driven; a monitor pops one entry after every rising edge.
// ---------------------------------------------------------------------------
module tb_neurosync_led_sequencer;

    localparam int ON   = 3;
    localparam int OFF  = 2;
    localparam int PER  = ON + OFF;
    localparam int NF   = 2;
    localparam int ND   = 4;

    logic       clock;
    logic       reset_n;
    logic       iniciar;
    logic       abortar;
    logic       nivel;
    logic [3:0] padrao;
    logic [3:0] leds;
    logic       ocupado;
    logic       fimPiscaLeds;
    logic [3:0] piscada_atual;
    logic [3:0] db_estado;

    // {db_estado[3:0], leds[3:0], ocupado, fimPiscaLeds, piscada_atual[3:0]}
    logic [13:0] exp_q[$];
    logic [13:0] mon_e;
    int          n_cmp;
    int          n_err;
    int          mon_cyc;

    neurosync_led_sequencer #(
        .ON_CYCLES        (ON),
        .OFF_CYCLES       (OFF),
        .PISCADAS_FACIL   (NF),
        .PISCADAS_DIFICIL (ND)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .iniciar       (iniciar),
        .abortar       (abortar),
        .nivel         (nivel),
        .padrao        (padrao),
        .leds          (leds),
        .ocupado       (ocupado),
        .fimPiscaLeds  (fimPiscaLeds),
        .piscada_atual (piscada_atual),
        .db_estado     (db_estado)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- expected-value model ----------------
    // Expected outputs in cycle c (1-based) of a presentation of n blinks.
    function automatic logic [13:0] exp_at(input logic [3:0] pad, input int n, input int c);
        int b;
        int p;
        if (c == n * PER + 1) return {4'd3, 4'd0, 1'b1, 1'b1, 4'(n)};
        b = (c - 1) / PER;
        p = (c - 1) % PER;
        if (p < ON) return {4'd1, pad, 1'b1, 1'b0, 4'(b)};
        return {4'd2, 4'd0, 1'b1, 1'b0, 4'(b + 1)};
    endfunction

    function automatic logic [13:0] idle(input logic [3:0] pisc);
        return {4'd0, 4'd0, 1'b0, 1'b0, pisc};
    endfunction

    // ---------------- driver ----------------
    // Drive inputs for the next rising edge and queue the outputs expected
    // in the cycle that edge starts.
    task automatic drive(input logic ini, input logic abo, input logic niv,
                         input logic [3:0] pad, input logic [13:0] e);
        @(negedge clock);
        iniciar = ini;
        abortar = abo;
        nivel   = niv;
        padrao  = pad;
        exp_q.push_back(e);
    endtask

    // One full presentation started with a single-cycle iniciar, then one idle cycle.
    task automatic present(input logic [3:0] pad, input logic niv, input int n);
        for (int c = 0; c <= n * PER; c++) begin
            drive(c == 0, 1'b0, niv, pad, exp_at(pad, n, c + 1));
        end
        drive(1'b0, 1'b0, niv, pad, idle(4'(n)));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_cyc++;
            check_eq($sformatf("db_estado@%0d", mon_cyc), 32'(db_estado), 32'(mon_e[13:10]));
            check_eq($sformatf("leds@%0d", mon_cyc), 32'(leds), 32'(mon_e[9:6]));
            check_eq($sformatf("ocupado@%0d", mon_cyc), 32'(ocupado), 32'(mon_e[5]));
            check_eq($sformatf("fim@%0d", mon_cyc), 32'(fimPiscaLeds), 32'(mon_e[4]));
            check_eq($sformatf("piscada@%0d", mon_cyc), 32'(piscada_atual), 32'(mon_e[3:0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp   = 0;
        n_err   = 0;
        mon_cyc = 0;
        reset_n = 1'b0;
        iniciar = 1'b0;
        abortar = 1'b0;
        nivel   = 1'b0;
        padrao  = 4'd0;

        repeat (3) @(posedge clock);
        #2;
        check_eq("rst_leds", 32'(leds), 32'd0);
        check_eq("rst_ocupado", 32'(ocupado), 32'd0);
        check_eq("rst_fim", 32'(fimPiscaLeds), 32'd0);
        check_eq("rst_piscada", 32'(piscada_atual), 32'd0);
        check_eq("rst_db_estado", 32'(db_estado), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        drive(1'b0, 1'b0, 1'b0, 4'd0, idle(4'd0));

        // Easy level: two blinks, fim in cycle 11.
        present(4'b1010, 1'b0, NF);

        // Hard level: four blinks, fim in cycle 21.
        present(4'b0110, 1'b1, ND);

        // Mid-presentation start request and input changes are ignored.
        for (int c = 0; c <= NF * PER; c++) begin
            drive((c == 0) || (c == 4), 1'b0, (c >= 4), (c >= 4) ? 4'b1111 : 4'b1010,
                  exp_at(4'b1010, NF, c + 1));
        end
        drive(1'b0, 1'b0, 1'b0, 4'b1010, idle(4'(NF)));

        // Abort during the second on-phase: dark and idle from cycle 8, no pulse.
        for (int c = 0; c <= 7; c++) begin
            drive(c == 0, c == 7, 1'b0, 4'b1010,
                  (c < 7) ? exp_at(4'b1010, NF, c + 1) : idle(4'd0));
        end
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b0, 1'b0, 4'b1010, idle(4'd0));
        end
        // abortar together with iniciar in OCIOSO: stays idle.
        drive(1'b1, 1'b1, 1'b0, 4'b1010, idle(4'd0));
        drive(1'b0, 1'b0, 1'b0, 4'b1010, idle(4'd0));
        present(4'b0101, 1'b1, ND);

        // iniciar held high: back-to-back, fim in cycles 11 and 23.
        for (int c = 0; c <= 23; c++) begin
            drive(1'b1, 1'b0, 1'b0, 4'b1100,
                  ((c + 1) == 12 || (c + 1) == 24) ? idle(4'(NF)) :
                  ((c + 1) < 12) ? exp_at(4'b1100, NF, c + 1) :
                                   exp_at(4'b1100, NF, c + 1 - 12));
        end
        drive(1'b0, 1'b0, 1'b0, 4'b1100, idle(4'(NF)));

        // All-dark pattern keeps normal timing.
        present(4'b0000, 1'b0, NF);

        // Asynchronous reset in the middle of the first off-phase.
        for (int c = 0; c <= 3; c++) begin
            drive(c == 0, 1'b0, 1'b0, 4'b1010, exp_at(4'b1010, NF, c + 1));
        end
        drive(1'b0, 1'b0, 1'b0, 4'b1010, exp_at(4'b1010, NF, 5));
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("arst_leds", 32'(leds), 32'd0);
        check_eq("arst_ocupado", 32'(ocupado), 32'd0);
        check_eq("arst_piscada", 32'(piscada_atual), 32'd0);
        check_eq("arst_db_estado", 32'(db_estado), 32'd0);
        check_eq("arst_fim", 32'(fimPiscaLeds), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Normal operation after the reset.
        present(4'b1001, 1'b0, NF);

        @(posedge clock);
        #3;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
